// File: rtl/rggen_external_responder_pkg.sv
// Shared rggen access and response codes for the external-bus responder.
package rggen_external_responder_pkg;

  typedef enum logic [1:0] {
    ACCESS_ILLEGAL      = 2'b00,
    ACCESS_POSTED_WRITE = 2'b01,
    ACCESS_READ         = 2'b10,
    ACCESS_WRITE        = 2'b11
  } rggen_access_e;

  typedef enum logic [1:0] {
    STATUS_OKAY         = 2'b00,
    STATUS_EXOKAY       = 2'b01,
    STATUS_SLAVE_ERROR  = 2'b10,
    STATUS_DECODE_ERROR = 2'b11
  } rggen_status_e;

  function automatic logic is_write_access(input logic [1:0] access);
    return (access == ACCESS_WRITE) || (access == ACCESS_POSTED_WRITE);
  endfunction

endpackage

// File: rtl/rggen_timeout_counter.sv
// Counts backend wait cycles; expired flags the last permitted cycle (never when TIMEOUT is 0).
module rggen_timeout_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned WIDTH = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WIDTH-1:0] LAST = WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [WIDTH-1:0] count;

  assign expired = (TIMEOUT != 0) && enable && (count == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rggen_external_responder.sv
// External-bus responder: decodes the window, runs one backend access and
// returns a single-cycle response with status and read data.
module rggen_external_responder
  import rggen_external_responder_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 8,
  parameter int          BUS_WIDTH     = 32,
  parameter int          STROBE_WIDTH  = BUS_WIDTH / 8,
  parameter int          BYTE_SIZE     = 256,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_external_valid,
  input  logic [1:0]               i_external_access,
  input  logic [ADDRESS_WIDTH-1:0] i_external_address,
  input  logic [BUS_WIDTH-1:0]     i_external_data,
  input  logic [STROBE_WIDTH-1:0]  i_external_strobe,
  output logic                     o_external_ready,
  output logic [1:0]               o_external_status,
  output logic [BUS_WIDTH-1:0]     o_external_data,
  output logic                     o_mem_req,
  output logic                     o_mem_write,
  output logic [ADDRESS_WIDTH-1:0] o_mem_address,
  output logic [BUS_WIDTH-1:0]     o_mem_write_data,
  output logic [BUS_WIDTH-1:0]     o_mem_bit_mask,
  input  logic                     i_mem_ack,
  input  logic                     i_mem_error,
  input  logic [BUS_WIDTH-1:0]     i_mem_read_data
);

  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK   = ~ADDRESS_WIDTH'(STROBE_WIDTH - 1);
  localparam logic [ADDRESS_WIDTH:0]   WINDOW_LIMIT = (ADDRESS_WIDTH + 1)'(BYTE_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    RESP
  } state_e;

  state_e               state;
  logic                 in_window;
  logic                 write_access;
  logic                 expired;
  logic [BUS_WIDTH-1:0] strobe_mask;

  assign in_window    = {1'b0, i_external_address} < WINDOW_LIMIT;
  assign write_access = is_write_access(i_external_access);

  always_comb begin
    strobe_mask = '0;
    for (int unsigned i = 0; i < STROBE_WIDTH; i++) begin
      strobe_mask[8*i+:8] = {8{i_external_strobe[i]}};
    end
  end

  rggen_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .enable  (o_mem_req),
    .clear   (!o_mem_req),
    .expired (expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      o_external_ready  <= 1'b0;
      o_external_status <= STATUS_OKAY;
      o_external_data   <= '0;
      o_mem_req         <= 1'b0;
      o_mem_write       <= 1'b0;
      o_mem_address     <= '0;
      o_mem_write_data  <= '0;
      o_mem_bit_mask    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // An out-of-window address reports a decode error even when the access code is illegal.
          if (i_external_valid) begin
            if (!in_window) begin
              state             <= RESP;
              o_external_ready  <= 1'b1;
              o_external_status <= STATUS_DECODE_ERROR;
            end else if (i_external_access == ACCESS_ILLEGAL) begin
              state             <= RESP;
              o_external_ready  <= 1'b1;
              o_external_status <= STATUS_SLAVE_ERROR;
            end else begin
              state            <= MEM;
              o_mem_req        <= 1'b1;
              o_mem_write      <= write_access;
              o_mem_address    <= i_external_address & ALIGN_MASK;
              o_mem_write_data <= i_external_data;
              o_mem_bit_mask   <= write_access ? strobe_mask : '0;
            end
          end
        end
        MEM: begin
          if (i_mem_ack) begin
            state             <= RESP;
            o_mem_req         <= 1'b0;
            o_external_ready  <= 1'b1;
            o_external_status <= i_mem_error ? STATUS_SLAVE_ERROR : STATUS_OKAY;
            o_external_data   <= o_mem_write ? '0 : i_mem_read_data;
          end else if (expired) begin
            state             <= RESP;
            o_mem_req         <= 1'b0;
            o_external_ready  <= 1'b1;
            o_external_status <= STATUS_SLAVE_ERROR;
            o_external_data   <= '0;
          end
        end
        RESP: begin
          state             <= IDLE;
          o_external_ready  <= 1'b0;
          o_external_status <= STATUS_OKAY;
          o_external_data   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_external_responder.sv
// Scoreboard bench for rggen_external_responder (ADDRESS_WIDTH=12, TIMEOUT=4).
module tb_rggen_external_responder;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] data;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [1:0]  access;
  logic [11:0] address;
  logic [31:0] wdata;
  logic [3:0]  strobe;
  logic        ext_ready;
  logic [1:0]  ext_status;
  logic [31:0] ext_data;
  logic        mem_req;
  logic        mem_write;
  logic [11:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_bit_mask;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_read_data;

  int compared   = 0;
  int mismatched = 0;

  resp_t exp_q[$];
  resp_t act_q[$];

  int          req_cycles;
  int          first_req_cyc;
  int          ready_cyc;
  logic [11:0] first_addr;
  logic        first_write;
  logic [31:0] first_wdata;
  logic [31:0] first_mask;
  logic        fields_stable;
  logic        post_ready;
  logic [1:0]  post_status;

  rggen_external_responder #(
    .ADDRESS_WIDTH (12),
    .BUS_WIDTH     (32),
    .STROBE_WIDTH  (4),
    .BYTE_SIZE     (256),
    .TIMEOUT       (4)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_external_valid   (valid),
    .i_external_access  (access),
    .i_external_address (address),
    .i_external_data    (wdata),
    .i_external_strobe  (strobe),
    .o_external_ready   (ext_ready),
    .o_external_status  (ext_status),
    .o_external_data    (ext_data),
    .o_mem_req          (mem_req),
    .o_mem_write        (mem_write),
    .o_mem_address      (mem_address),
    .o_mem_write_data   (mem_write_data),
    .o_mem_bit_mask     (mem_bit_mask),
    .i_mem_ack          (mem_ack),
    .i_mem_error        (mem_error),
    .i_mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ext_ready === 1'b1) act_q.push_back({ext_status, ext_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Issues one request (valid held until ready) and records what the backend and response side showed.
  // ack_at is the number of cycles after the first req cycle at which ack is given; -1 means never.
  task automatic do_access(input logic [1:0] acc, input logic [11:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input int ack_at, input logic err, input logic [31:0] rd);
    req_cycles = 0; first_req_cyc = -1; ready_cyc = -1; fields_stable = 1'b1;
    first_addr = '0; first_write = 1'b0; first_wdata = '0; first_mask = '0;
    @(posedge clk); #1;
    valid = 1'b1; access = acc; address = addr; wdata = wd; strobe = strb;
    for (int cyc = 1; cyc <= 40 && ready_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      mem_ack       = (ack_at >= 0) && (cyc == ack_at + 1);
      mem_error     = err & mem_ack;
      mem_read_data = mem_ack ? rd : 32'hBAD0_BAD0;
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (req_cycles == 0) begin
          first_req_cyc = cyc; first_addr = mem_address; first_write = mem_write;
          first_wdata = mem_write_data; first_mask = mem_bit_mask;
        end else if ({mem_address, mem_write, mem_write_data, mem_bit_mask} !==
                     {first_addr, first_write, first_wdata, first_mask}) begin
          fields_stable = 1'b0;
        end
        req_cycles++;
      end
      if (ext_ready === 1'b1) ready_cyc = cyc;
    end
    @(posedge clk); #1;
    valid = 1'b0; mem_ack = 1'b0; mem_error = 1'b0;
    @(negedge clk);
    post_ready = ext_ready; post_status = ext_status;
  endtask

  task automatic test_reset();
    resp_t act;
    rst_n = 1'b0; valid = 1'b0; access = '0; address = '0; wdata = '0; strobe = '0;
    mem_ack = 1'b0; mem_error = 1'b0; mem_read_data = '0;
    act = '0;
    repeat (2) @(negedge clk);
    compared++;
    if ({mem_req, ext_ready, ext_status, ext_data} !== 36'h0) begin
      mismatched++;
      $display("FAIL reset_handshake: got req=%b ready=%b status=%b data=%h want all zero", mem_req, ext_ready, ext_status, ext_data);
    end
    compared++;
    if ({mem_write, mem_address, mem_write_data, mem_bit_mask} !== 77'h0) begin
      mismatched++;
      $display("FAIL reset_mem_fields: got write=%b addr=%h wdata=%h mask=%h want all zero", mem_write, mem_address, mem_write_data, mem_bit_mask);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    resp_t act, exp;
    exp_q.push_back({2'b00, 32'hDEADBEEF});
    do_access(2'b10, 12'h004, 32'h0, 4'hF, 2, 1'b0, 32'hDEADBEEF);
    compared++;
    if (first_req_cyc !== 1) begin mismatched++; $display("FAIL read_req_start: got %0d want 1", first_req_cyc); end
    compared++;
    if ({first_addr, first_write, first_mask} !== {12'h004, 1'b0, 32'h0}) begin
      mismatched++; $display("FAIL read_mem_fields: got addr=%h write=%b mask=%h want 004/0/00000000", first_addr, first_write, first_mask);
    end
    compared++;
    if (ready_cyc !== 4) begin mismatched++; $display("FAIL read_ready_latency: got %0d want 4", ready_cyc); end
    compared++;
    if ({post_ready, post_status} !== 3'b000) begin mismatched++; $display("FAIL read_ready_pulse: got ready=%b status=%b want 0/00", post_ready, post_status); end
    exp = exp_q.pop_front();
    compared++;
    if (act_q.size() == 0) begin mismatched++; $display("FAIL read_resp: got no response want %h", exp); end
    else begin
      act = act_q.pop_front();
      if (act !== exp) begin mismatched++; $display("FAIL read_resp: got %h want %h", act, exp); end
    end
  endtask

  task automatic test_write();
    resp_t act, exp;
    exp_q.push_back({2'b00, 32'h0});
    do_access(2'b11, 12'h00A, 32'h11223344, 4'b0101, 0, 1'b0, 32'hCAFEF00D);
    compared++;
    if ({first_addr, first_write, first_wdata, first_mask} !== {12'h008, 1'b1, 32'h11223344, 32'h00FF00FF}) begin
      mismatched++; $display("FAIL write_mem_fields: got addr=%h write=%b wdata=%h mask=%h want 008/1/11223344/00ff00ff",
                              first_addr, first_write, first_wdata, first_mask);
    end
    compared++;
    if (ready_cyc !== 2) begin mismatched++; $display("FAIL write_zero_wait_latency: got %0d want 2", ready_cyc); end
    exp = exp_q.pop_front();
    compared++;
    if (act_q.size() == 0) begin mismatched++; $display("FAIL write_resp: got no response want %h", exp); end
    else begin
      act = act_q.pop_front();
      if (act !== exp) begin mismatched++; $display("FAIL write_resp: got %h want %h", act, exp); end
    end
  endtask

  task automatic test_posted_write();
    resp_t act, exp;
    exp_q.push_back({2'b00, 32'h0});
    do_access(2'b01, 12'h0FF, 32'hA5A5A5A5, 4'b1000, 1, 1'b0, 32'h0);
    compared++;
    if ({first_addr, first_write, first_mask} !== {12'h0FC, 1'b1, 32'hFF000000}) begin
      mismatched++; $display("FAIL posted_mem_fields: got addr=%h write=%b mask=%h want 0fc/1/ff000000", first_addr, first_write, first_mask);
    end
    compared++;
    if (ready_cyc !== 3) begin mismatched++; $display("FAIL posted_latency: got %0d want 3", ready_cyc); end
    exp = exp_q.pop_front();
    compared++;
    if (act_q.size() == 0) begin mismatched++; $display("FAIL posted_resp: got no response want %h", exp); end
    else begin
      act = act_q.pop_front();
      if (act !== exp) begin mismatched++; $display("FAIL posted_resp: got %h want %h", act, exp); end
    end
  endtask

  task automatic test_decode_error();
    resp_t act, exp;
    exp_q.push_back({2'b11, 32'h0});
    do_access(2'b10, 12'h100, 32'h0, 4'hF, 0, 1'b0, 32'h55555555);
    compared++;
    if ({req_cycles, ready_cyc} !== {32'd0, 32'd1}) begin
      mismatched++; $display("FAIL decode_timing: got req_cycles=%0d ready_cyc=%0d want 0/1", req_cycles, ready_cyc);
    end
    exp = exp_q.pop_front();
    compared++;
    if (act_q.size() == 0) begin mismatched++; $display("FAIL decode_resp: got no response want %h", exp); end
    else begin
      act = act_q.pop_front();
      if (act !== exp) begin mismatched++; $display("FAIL decode_resp: got %h want %h", act, exp); end
    end
  endtask

  task automatic test_illegal_access();
    resp_t act, exp;
    exp_q.push_back({2'b10, 32'h0});
    do_access(2'b00, 12'h010, 32'h0, 4'hF, -1, 1'b0, 32'h0);
    compared++;
    if ({req_cycles, ready_cyc} !== {32'd0, 32'd1}) begin
      mismatched++; $display("FAIL illegal_timing: got req_cycles=%0d ready_cyc=%0d want 0/1", req_cycles, ready_cyc);
    end
    exp = exp_q.pop_front();
    compared++;
    if (act_q.size() == 0) begin mismatched++; $display("FAIL illegal_resp: got no response want %h", exp); end
    else begin
      act = act_q.pop_front();
      if (act !== exp) begin mismatched++; $display("FAIL illegal_resp: got %h want %h", act, exp); end
    end
  endtask

  task automatic test_timeout();
    resp_t act, exp;
    exp_q.push_back({2'b10, 32'h0});
    do_access(2'b10, 12'h020, 32'h0, 4'hF, -1, 1'b0, 32'h0);
    compared++;
    if ({req_cycles, ready_cyc} !== {32'd4, 32'd5}) begin
      mismatched++; $display("FAIL timeout_timing: got req_cycles=%0d ready_cyc=%0d want 4/5", req_cycles, ready_cyc);
    end
    compared++;
    if (fields_stable !== 1'b1) begin mismatched++; $display("FAIL timeout_fields_stable: got %b want 1", fields_stable); end
    exp = exp_q.pop_front();
    compared++;
    if (act_q.size() == 0) begin mismatched++; $display("FAIL timeout_resp: got no response want %h", exp); end
    else begin
      act = act_q.pop_front();
      if (act !== exp) begin mismatched++; $display("FAIL timeout_resp: got %h want %h", act, exp); end
    end
  endtask

  task automatic test_ack_at_expiry();
    resp_t act, exp;
    exp_q.push_back({2'b00, 32'h12345678});
    do_access(2'b10, 12'h024, 32'h0, 4'hF, 3, 1'b0, 32'h12345678);
    compared++;
    if ({req_cycles, ready_cyc} !== {32'd4, 32'd5}) begin
      mismatched++; $display("FAIL expiry_ack_timing: got req_cycles=%0d ready_cyc=%0d want 4/5", req_cycles, ready_cyc);
    end
    exp = exp_q.pop_front();
    compared++;
    if (act_q.size() == 0) begin mismatched++; $display("FAIL expiry_ack_resp: got no response want %h", exp); end
    else begin
      act = act_q.pop_front();
      if (act !== exp) begin mismatched++; $display("FAIL expiry_ack_resp: got %h want %h", act, exp); end
    end
  endtask

  task automatic test_mem_error();
    resp_t act, exp;
    exp_q.push_back({2'b10, 32'h0});
    do_access(2'b11, 12'h030, 32'hFFFF0000, 4'b1100, 1, 1'b1, 32'h0);
    compared++;
    if (ready_cyc !== 3) begin mismatched++; $display("FAIL error_latency: got %0d want 3", ready_cyc); end
    exp = exp_q.pop_front();
    compared++;
    if (act_q.size() == 0) begin mismatched++; $display("FAIL error_resp: got no response want %h", exp); end
    else begin
      act = act_q.pop_front();
      if (act !== exp) begin mismatched++; $display("FAIL error_resp: got %h want %h", act, exp); end
    end
  endtask

  task automatic test_back_to_back();
    resp_t act, exp;
    exp_q.push_back({2'b00, 32'h0000_0001});
    do_access(2'b10, 12'h000, 32'h0, 4'hF, 0, 1'b0, 32'h0000_0001);
    exp_q.push_back({2'b00, 32'h0});
    do_access(2'b11, 12'h0F0, 32'h0BAD_CAFE, 4'b0011, 0, 1'b0, 32'h0);
    exp_q.push_back({2'b11, 32'h0});
    do_access(2'b11, 12'hFFF, 32'h0, 4'hF, 0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      exp = exp_q.pop_front();
      compared++;
      if (act_q.size() == 0) begin mismatched++; $display("FAIL b2b_resp[%0d]: got no response want %h", k, exp); end
      else begin
        act = act_q.pop_front();
        if (act !== exp) begin mismatched++; $display("FAIL b2b_resp[%0d]: got %h want %h", k, act, exp); end
      end
    end
  endtask

  task automatic test_reset_mid_transaction();
    resp_t act, exp;
    int    resp_before;
    resp_before = act_q.size();
    @(posedge clk); #1;
    valid = 1'b1; access = 2'b10; address = 12'h040; strobe = 4'hF;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (mem_req !== 1'b1) begin mismatched++; $display("FAIL midreset_req_before: got %b want 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({mem_req, ext_ready, ext_status} !== 4'b0000) begin
      mismatched++; $display("FAIL midreset_immediate: got req=%b ready=%b status=%b want 0/0/00", mem_req, ext_ready, ext_status);
    end
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compared++;
    if (act_q.size() !== resp_before) begin mismatched++; $display("FAIL midreset_no_ready: got %0d responses want %0d", act_q.size(), resp_before); end
    exp_q.push_back({2'b00, 32'h0BAD_F00D});
    do_access(2'b10, 12'h044, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_F00D);
    compared++;
    if ({first_addr, ready_cyc} !== {12'h044, 32'd2}) begin
      mismatched++; $display("FAIL midreset_recover_timing: got addr=%h ready_cyc=%0d want 044/2", first_addr, ready_cyc);
    end
    exp = exp_q.pop_front();
    compared++;
    if (act_q.size() == 0) begin mismatched++; $display("FAIL midreset_recover_resp: got no response want %h", exp); end
    else begin
      act = act_q.pop_front();
      if (act !== exp) begin mismatched++; $display("FAIL midreset_recover_resp: got %h want %h", act, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_posted_write();
    test_decode_error();
    test_illegal_access();
    test_timeout();
    test_ack_at_expiry();
    test_mem_error();
    test_back_to_back();
    test_reset_mid_transaction();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rggen_external_responder.md
RGGEN_EXTERNAL_RESPONDER -- requirements
Module: rggen_external_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, the external bus byte-address width.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, the data width (multiple of 8).
REQ-003 SHALL have parameter STROBE_WIDTH, default BUS_WIDTH/8, the byte-strobe width.
REQ-004 SHALL have parameter BYTE_SIZE, default 256, the size of the decoded window in bytes.
REQ-005 SHALL have parameter TIMEOUT, default 15, the maximum backend wait in cycles; 0 disables the timeout.
REQ-006 SHALL have port i_clk, input, 1, the clock.
REQ-007 SHALL have port i_rst_n, input, 1, the reset: asynchronous, active-low.
REQ-008 SHALL have port i_external_valid, input, 1, the request valid.
REQ-009 SHALL have port i_external_access, input, 2, the access type: 2'b10 read, 2'b11 write, 2'b01 posted write, 2'b00 illegal.
REQ-010 SHALL have port i_external_address, input, ADDRESS_WIDTH, the window-relative byte address.
REQ-011 SHALL have port i_external_data, input, BUS_WIDTH, the write data.
REQ-012 SHALL have port i_external_strobe, input, STROBE_WIDTH, the byte enables.
REQ-013 SHALL have port o_external_ready, output, 1, the response valid, a single-cycle pulse.
REQ-014 SHALL have port o_external_status, output, 2, the response status: 00 OKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR.
REQ-015 SHALL have port o_external_data, output, BUS_WIDTH, the read data.
REQ-016 SHALL have port o_mem_req, output, 1, the backend request, held until ack.
REQ-017 SHALL have port o_mem_write, output, 1, where 1 means write.
REQ-018 SHALL have port o_mem_address, output, ADDRESS_WIDTH, the word-aligned address (low log2(STROBE_WIDTH) bits zero).
REQ-019 SHALL have port o_mem_write_data, output, BUS_WIDTH, the registered write data.
REQ-020 SHALL have port o_mem_bit_mask, output, BUS_WIDTH, the strobe bits each expanded to 8 bits, all zero for reads.
REQ-021 SHALL have port i_mem_ack, input, 1, the backend completion.
REQ-022 SHALL have port i_mem_error, input, 1, the backend error, qualified by i_mem_ack.
REQ-023 SHALL have port i_mem_read_data, input, BUS_WIDTH, the read data, qualified by i_mem_ack.

Function
REQ-024 SHALL implement an FSM with states IDLE, MEM and RESP.
REQ-025 SHALL, in IDLE with valid and a legal access and address < BYTE_SIZE, register the access fields and go to MEM.
REQ-026 SHALL, in IDLE with valid and address >= BYTE_SIZE, go to RESP with status 11 and data 0; o_mem_req stays 0.
REQ-027 SHALL, in IDLE with valid and access 2'b00, go to RESP with status 10 and data 0; no backend access.
REQ-028 SHALL drive o_mem_req=1 throughout MEM and SHALL keep all o_mem_* fields stable while o_mem_req=1.
REQ-029 SHALL, in MEM on i_mem_ack, capture status (10 if i_mem_error, else 00) and, for reads, i_mem_read_data; it SHALL then go to RESP.
REQ-030 SHALL count MEM cycles; when TIMEOUT!=0 and the count reaches TIMEOUT without ack, it SHALL drop o_mem_req and go to RESP with status 10 and data 0.
REQ-031 SHALL give ack priority when ack coincides with timeout expiry.
REQ-032 SHALL assert o_external_ready only in RESP, for exactly one cycle, then return to IDLE.
REQ-033 SHALL drive o_external_data to the captured read data in RESP for reads, otherwise 0; o_external_status SHALL be 00 outside RESP.
REQ-034 SHALL treat posted writes identically to writes, with a response after ack.
REQ-035 SHALL ignore i_external_valid in MEM and RESP; the initiator holds its request until ready.
REQ-036 SHALL meet this latency: valid sampled in IDLE at cycle N, req from N+1, ack at M, ready at M+1; a zero-wait ack gives ready at N+2; a decode error gives ready at N+1.
REQ-037 SHALL ignore i_mem_ack outside MEM.

Reset
REQ-038 SHALL, on i_rst_n low at any time including mid-transaction, enter IDLE with o_mem_req=0, o_external_ready=0, status 00, o_external_data=0 and the counter at 0.
REQ-039 SHALL reset o_mem_write, o_mem_address, o_mem_write_data and o_mem_bit_mask to 0.

Structure
REQ-040 SHALL take the access codes (READ/WRITE/POSTED_WRITE) and status codes (OKAY/SLAVE_ERROR/DECODE_ERROR) from the shared rggen RTL package/header, not from local literals.
REQ-041 SHALL keep the FSM state encoding local to the module.
REQ-042 SHALL place the timeout counter in one sub-module, rggen_timeout_counter (inputs: enable, clear; output: expired).

Verification
REQ-043 SHALL cover a read to 0x04 with ack 2 cycles after req and data 0xDEADBEEF, expecting req at N+1, mem_address 0x04, ready one cycle after ack, data 0xDEADBEEF, status 00.
REQ-044 SHALL cover a write to 0x0A with strobe 4'b0101 and data 0x11223344, expecting mem_address 0x08, bit_mask 0x00FF00FF, write=1, status 00 and data 0.
REQ-045 SHALL cover a read to 0x100 with BYTE_SIZE=256, ADDRESS_WIDTH=12, expecting no mem_req, ready at N+1 and status 11.
REQ-046 SHALL cover TIMEOUT=4 with no ack, expecting req high for 4 cycles, then low, then ready with status 10 and data 0.
REQ-047 SHALL cover ack with i_mem_error=1 on a write, and separately ack on the same cycle as timeout expiry, expecting status 10 and status 00 respectively.
REQ-048 SHALL cover i_rst_n asserted during MEM, expecting req to drop immediately, no ready, and a subsequent read completing normally.
